// File: rtl/battle_referee.sv
`default_nettype none
// ============================================================================
//  Module      : battle_referee
//  Description : Scoreboard and answer-window timer for the factorization
//                battle game. Tracks player/enemy HP, counts down the answer
//                window, applies judged outcomes as damage and reports the
//                game-end code (00 ongoing, 01 player won, 10 player lost).
//  Revision    : 1.0  initial release
// ============================================================================
module battle_referee #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int HP_INIT    = 3,
  parameter int TIME_LIMIT = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Q_BEGIN,
  input  logic       JUDG_VLD,
  input  logic [1:0] JUDG_IN,
  output logic [1:0] HP_OUT,
  output logic [2:0] P_HP,
  output logic [2:0] E_HP,
  output logic [3:0] TIME_LEFT,
  output logic       TIMEOUT,
  output logic [1:0] LAST_RES,
  output logic       BUSY
);

  // Prescaler width; a 1-cycle "second" still needs a 1-bit counter.
  localparam int              PS_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(CLK_HZ - 1);
  localparam logic [2:0]      HP_RELOAD = 3'(HP_INIT);
  localparam logic [3:0]      TL_RELOAD = 4'(TIME_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_TIMING  = 3'd2,
    S_RESOLVE = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t          state;
  logic [PS_W-1:0] prescaler;
  logic            wrap;
  logic            judge_hit;

  // HP never wraps below zero.
  function automatic logic [2:0] dec_sat(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  assign wrap      = (prescaler == PS_LAST);
  // A "no result" code is treated as if no verdict arrived at all.
  assign judge_hit = JUDG_VLD && (JUDG_IN != 2'b00);
  assign BUSY      = (state == S_TIMING) || (state == S_RESOLVE);

  // Game controller: state, HP bookkeeping, countdown and result reporting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      prescaler <= '0;
      P_HP      <= HP_RELOAD;
      E_HP      <= HP_RELOAD;
      HP_OUT    <= 2'b00;
      TIME_LEFT <= 4'd0;
      TIMEOUT   <= 1'b0;
      LAST_RES  <= 2'b00;
    end else if (START) begin
      state     <= S_ARMED;
      prescaler <= '0;
      P_HP      <= HP_RELOAD;
      E_HP      <= HP_RELOAD;
      HP_OUT    <= 2'b00;
      TIME_LEFT <= 4'd0;
      TIMEOUT   <= 1'b0;
      LAST_RES  <= 2'b00;
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        S_IDLE: begin
        end

        S_ARMED: begin
          if (Q_BEGIN) begin
            TIME_LEFT <= TL_RELOAD;
            prescaler <= '0;
            state     <= S_TIMING;
          end
        end

        S_TIMING: begin
          if (judge_hit) begin
            // A verdict always wins over an expiring window; the last
            // second stays displayed instead of dropping to zero.
            if (JUDG_IN == 2'b01) E_HP <= dec_sat(E_HP);
            if (JUDG_IN == 2'b10) P_HP <= dec_sat(P_HP);
            LAST_RES  <= JUDG_IN;
            prescaler <= wrap ? '0 : prescaler + PS_W'(1);
            if (wrap && (TIME_LEFT > 4'd1)) TIME_LEFT <= TIME_LEFT - 4'd1;
            state     <= S_RESOLVE;
          end else if (Q_BEGIN) begin
            TIME_LEFT <= TL_RELOAD;
            prescaler <= '0;
          end else if (wrap) begin
            prescaler <= '0;
            if (TIME_LEFT <= 4'd1) begin
              TIME_LEFT <= 4'd0;
              TIMEOUT   <= 1'b1;
              P_HP      <= dec_sat(P_HP);
              LAST_RES  <= 2'b10;
              state     <= S_RESOLVE;
            end else begin
              TIME_LEFT <= TIME_LEFT - 4'd1;
            end
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end

        S_RESOLVE: begin
          if (E_HP == 3'd0) begin
            HP_OUT <= 2'b01;
            state  <= S_OVER;
          end else if (P_HP == 3'd0) begin
            HP_OUT <= 2'b10;
            state  <= S_OVER;
          end else begin
            state  <= S_ARMED;
          end
        end

        S_OVER: begin
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_battle_referee.sv
`default_nettype none
// ============================================================================
//  Module      : tb_battle_referee
//  Description : Self-checking bench for battle_referee. A game-level model
//                (elapsed-cycle deadline, HP counters) predicts every output
//                each cycle; directed scenarios add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_battle_referee;

  localparam int CLK_HZ     = 4;
  localparam int HP_INIT    = 2;
  localparam int TIME_LIMIT = 3;
  localparam int DEADLINE   = CLK_HZ * TIME_LIMIT;

  // Model game phases
  localparam int P_IDLE    = 0;
  localparam int P_WAITQ   = 1;
  localparam int P_ANSWER  = 2;
  localparam int P_VERDICT = 3;
  localparam int P_DONE    = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       Q_BEGIN = 1'b0;
  logic       JUDG_VLD = 1'b0;
  logic [1:0] JUDG_IN = 2'b00;
  logic [1:0] HP_OUT;
  logic [2:0] P_HP;
  logic [2:0] E_HP;
  logic [3:0] TIME_LEFT;
  logic       TIMEOUT;
  logic [1:0] LAST_RES;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_phase = P_IDLE;
  int m_elapsed = 0;
  int m_p = HP_INIT, m_e = HP_INIT, m_tl = 0, m_hpout = 0, m_last = 0;
  bit m_to = 1'b0;

  battle_referee #(
    .CLK_HZ    (CLK_HZ),
    .HP_INIT   (HP_INIT),
    .TIME_LIMIT(TIME_LIMIT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .Q_BEGIN  (Q_BEGIN),
    .JUDG_VLD (JUDG_VLD),
    .JUDG_IN  (JUDG_IN),
    .HP_OUT   (HP_OUT),
    .P_HP     (P_HP),
    .E_HP     (E_HP),
    .TIME_LEFT(TIME_LEFT),
    .TIMEOUT  (TIMEOUT),
    .LAST_RES (LAST_RES),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic int hit(input int hp);
    return (hp > 0) ? hp - 1 : 0;
  endfunction

  // Advance the game model by one clock edge given that edge's inputs.
  task automatic model_step(input bit r, input bit s, input bit q, input bit v,
                            input logic [1:0] j);
    m_to = 1'b0;
    if (r) begin
      m_phase = P_IDLE; m_p = HP_INIT; m_e = HP_INIT;
      m_hpout = 0; m_tl = 0; m_last = 0; m_elapsed = 0;
    end else if (s) begin
      m_phase = P_WAITQ; m_p = HP_INIT; m_e = HP_INIT;
      m_hpout = 0; m_tl = 0; m_last = 0; m_elapsed = 0;
    end else begin
      case (m_phase)
        P_WAITQ: if (q) begin
          m_elapsed = 0; m_tl = TIME_LIMIT; m_phase = P_ANSWER;
        end
        P_ANSWER: begin
          if (v && j != 2'b00) begin
            if (j == 2'b01) m_e = hit(m_e);
            if (j == 2'b10) m_p = hit(m_p);
            m_last = int'(j);
            // The final second is never consumed when a verdict lands on it.
            if (m_elapsed + 1 < DEADLINE) m_elapsed++;
            m_tl = TIME_LIMIT - m_elapsed / CLK_HZ;
            m_phase = P_VERDICT;
          end else if (q) begin
            m_elapsed = 0; m_tl = TIME_LIMIT;
          end else begin
            m_elapsed++;
            m_tl = TIME_LIMIT - m_elapsed / CLK_HZ;
            if (m_elapsed == DEADLINE) begin
              m_to = 1'b1; m_p = hit(m_p); m_last = 2; m_phase = P_VERDICT;
            end
          end
        end
        P_VERDICT: begin
          if (m_e == 0)      begin m_hpout = 1; m_phase = P_DONE; end
          else if (m_p == 0) begin m_hpout = 2; m_phase = P_DONE; end
          else               m_phase = P_WAITQ;
        end
        default: ;
      endcase
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic compare_all();
    logic [15:0] got, req;
    logic        m_busy;
    m_busy = (m_phase == P_ANSWER) || (m_phase == P_VERDICT);
    got = {HP_OUT, P_HP, E_HP, TIME_LEFT, TIMEOUT, LAST_RES, BUSY};
    req = {2'(m_hpout), 3'(m_p), 3'(m_e), 4'(m_tl), m_to, 2'(m_last), m_busy};
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL model_cmp t=%0t actual={hp_out,p,e,tl,to,last,busy}=%h required=%h",
               $time, got, req);
    end
  endtask

  // Literal expectation used to pin the model in directed scenarios.
  task automatic lit(input string name, input int actual, input int req);
    total++;
    if (actual != req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, actual, req);
    end
  endtask

  // One clock: drive inputs, step model on the edge, check on the falling edge.
  task automatic cyc(input bit r, input bit s, input bit q, input bit v,
                     input logic [1:0] j);
    RST = r; START = s; Q_BEGIN = q; JUDG_VLD = v; JUDG_IN = j;
    @(posedge CLK);
    model_step(r, s, q, v, j);
    @(negedge CLK);
    RST = 1'b0; START = 1'b0; Q_BEGIN = 1'b0; JUDG_VLD = 1'b0; JUDG_IN = 2'b00;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 2'b00);
  endtask

  initial begin
    // Reset values, and judge pulses ignored in IDLE/ARMED
    cyc(1, 0, 0, 0, 2'b00);
    lit("rst_p_hp", P_HP, 2);     lit("rst_e_hp", E_HP, 2);
    lit("rst_hp_out", HP_OUT, 0); lit("rst_time_left", TIME_LEFT, 0);
    lit("rst_busy", BUSY, 0);     lit("rst_last", LAST_RES, 0);
    cyc(0, 0, 0, 1, 2'b01);       lit("idle_judge_e_hp", E_HP, 2);
    cyc(0, 1, 0, 0, 2'b00);       lit("armed_busy", BUSY, 0);
    cyc(0, 0, 0, 1, 2'b01);       lit("armed_judge_e_hp", E_HP, 2);

    // Player wins over two questions
    cyc(0, 0, 1, 0, 2'b00);       lit("qb_time_left", TIME_LEFT, 3); lit("qb_busy", BUSY, 1);
    cyc(0, 0, 0, 1, 2'b01);       lit("win1_e_hp", E_HP, 1); lit("win1_last", LAST_RES, 1);
    idle(1);                      lit("win1_hp_out", HP_OUT, 0); lit("win1_busy", BUSY, 0);
    cyc(0, 0, 1, 0, 2'b00);
    cyc(0, 0, 0, 1, 2'b01);       lit("win2_e_hp", E_HP, 0); lit("win2_hp_out_early", HP_OUT, 0);
    idle(1);                      lit("win2_hp_out", HP_OUT, 1);
    cyc(0, 0, 0, 1, 2'b10);       lit("over_judge_p_hp", P_HP, 2); lit("over_hp_out", HP_OUT, 1);
    cyc(0, 0, 1, 0, 2'b00);       lit("over_qb_busy", BUSY, 0);
    cyc(0, 1, 0, 0, 2'b00);       lit("restart_e_hp", E_HP, 2); lit("restart_hp_out", HP_OUT, 0);
    lit("restart_last", LAST_RES, 0);

    // Timeouts: countdown spacing, pulse 12 cycles after Q_BEGIN, player loses
    cyc(0, 0, 1, 0, 2'b00);
    idle(3);                      lit("tl_at3", TIME_LEFT, 3);
    idle(1);                      lit("tl_at4", TIME_LEFT, 2);
    idle(4);                      lit("tl_at8", TIME_LEFT, 1);
    idle(3);                      lit("to_at11", TIMEOUT, 0);
    idle(1);                      lit("to_at12", TIMEOUT, 1); lit("to_tl", TIME_LEFT, 0);
    lit("to_p_hp", P_HP, 1);      lit("to_last", LAST_RES, 2);
    idle(1);                      lit("to_pulse_end", TIMEOUT, 0); lit("to_hp_out", HP_OUT, 0);
    cyc(0, 0, 1, 0, 2'b00);
    idle(12);                     lit("to2_p_hp", P_HP, 0);
    idle(1);                      lit("lose_hp_out", HP_OUT, 2);

    // Verdict on the final wrap beats the timeout
    cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 2'b00);
    idle(11);
    cyc(0, 0, 0, 1, 2'b01);       lit("race_e_hp", E_HP, 1); lit("race_to", TIMEOUT, 0);
    lit("race_p_hp", P_HP, 2);    lit("race_tl", TIME_LEFT, 1);
    idle(1);                      lit("race_to_after", TIMEOUT, 0);

    // Draw then no-result
    cyc(0, 0, 1, 0, 2'b00);
    cyc(0, 0, 0, 1, 2'b11);       lit("draw_last", LAST_RES, 3); lit("draw_p_hp", P_HP, 2);
    lit("draw_e_hp", E_HP, 1);
    idle(1);
    cyc(0, 0, 1, 0, 2'b00);
    cyc(0, 0, 0, 1, 2'b00);       lit("noresult_busy", BUSY, 1); lit("noresult_last", LAST_RES, 3);

    // Window restart at TIME_LEFT=1
    cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 2'b00);
    idle(9);                      lit("restart_tl_before", TIME_LEFT, 1);
    cyc(0, 0, 1, 0, 2'b00);       lit("restart_tl_after", TIME_LEFT, 3);
    for (int k = 0; k < 11; k++) begin
      idle(1);
      lit("restart_no_to", TIMEOUT, 0);
    end
    idle(1);                      lit("restart_to_12", TIMEOUT, 1);

    // Reset mid-window on the expiring cycle
    cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 2'b00);
    idle(11);
    cyc(1, 0, 0, 0, 2'b00);       lit("midrst_to", TIMEOUT, 0); lit("midrst_tl", TIME_LEFT, 0);
    lit("midrst_busy", BUSY, 0);  lit("midrst_p_hp", P_HP, 2);
    cyc(0, 0, 1, 0, 2'b00);       lit("idle_qb_tl", TIME_LEFT, 0);

    // Randomized play against the model; later phase favours timeouts
    for (int n = 0; n < 4000; n++) begin
      bit r, s, q, v;
      logic [1:0] j;
      int qd, vd;
      qd = (n < 2000) ? 8 : 30;
      vd = (n < 2000) ? 5 : 25;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, vd - 1) == 0);
      q = !v && ($urandom_range(0, qd - 1) == 0);
      j = 2'($urandom_range(0, 3));
      cyc(r, s, q, v, j);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
